hr_ser_lane_array: RTL and testbench

//  Parametrised half-rate N-lane serializer, successor to the fixed 16:4 mux.

---
 rtl/hr_ser_pkg.sv | 19 +
 rtl/hr_ser_lane_array_if.sv | 41 ++++
 rtl/hr_ser_lane.sv | 44 ++++
 rtl/hr_ser_lane_array.sv | 147 ++++++++++++++
 tb/tb_hr_ser_lane_array.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hr_ser_pkg.sv
// -----------------------------------------------------------------------------
// hr_ser_pkg
// Purpose : Shared types and constants for the half-rate lane serializer.
//           It is imported by the interface and the top-level module.
// Contents: ser_mode_e - pattern select applied at word boundaries
//           PRBS_SEED  - PRBS7 generator state after reset and on PRBS7 entry
// -----------------------------------------------------------------------------
package hr_ser_pkg;

  typedef enum logic [1:0] {
    SER_DATA  = 2'd0,
    SER_PRBS7 = 2'd1,
    SER_CLK   = 2'd2,
    SER_ZERO  = 2'd3
  } ser_mode_e;

  localparam logic [6:0] PRBS_SEED = 7'h7F;

endpackage

// File: rtl/hr_ser_lane_array_if.sv
// -----------------------------------------------------------------------------
// hr_ser_lane_array_if
// Purpose : Groups the load handshake, control and serial output signals of
//           hr_ser_lane_array into one bundle.
// Signals : din/din_valid/din_ready - parallel word load handshake
//           mode, lane_en, clr_status - control inputs
//           dout_e/dout_o            - per-lane even/odd output pair
//           underflow, word_cnt      - status outputs
// Modports: master - the word source and controller (drives din, mode, ...)
//           slave  - the serializer itself
// -----------------------------------------------------------------------------
interface hr_ser_lane_array_if
  import hr_ser_pkg::*;
#(
  parameter int LANES = 4,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
);

  logic [LANES*RATIO-1:0] din;
  logic                   din_valid;
  logic                   din_ready;
  ser_mode_e              mode;
  logic [LANES-1:0]       lane_en;
  logic                   clr_status;
  logic [LANES-1:0]       dout_e;
  logic [LANES-1:0]       dout_o;
  logic                   underflow;
  logic [CNT_W-1:0]       word_cnt;

  modport master (
    output din, din_valid, mode, lane_en, clr_status,
    input  din_ready, dout_e, dout_o, underflow, word_cnt
  );

  modport slave (
    input  din, din_valid, mode, lane_en, clr_status,
    output din_ready, dout_e, dout_o, underflow, word_cnt
  );

endinterface

// File: rtl/hr_ser_lane.sv
// -----------------------------------------------------------------------------
// hr_ser_lane
// Purpose : One output lane of the serializer. Holds the lane's RATIO-bit
//           slice, moves it two bits per cycle and presents the current pair.
// Ports   : clk_hr   - half-rate clock
//           rst      - synchronous active-high reset
//           i_load   - load i_slice this edge (word boundary)
//           i_slice  - this lane's slice of the incoming word (or idle zeros)
//           o_bitE   - earlier bit of the current pair (combinational)
//           o_bitO   - later bit of the current pair (combinational)
// -----------------------------------------------------------------------------
module hr_ser_lane #(
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_hr,
  input  logic             rst,
  input  logic             i_load,
  input  logic [RATIO-1:0] i_slice,
  output logic             o_bitE,
  output logic             o_bitO
);

  logic [RATIO-1:0] r_shift;

  // The next pair always sits at the end that leaves first, so the pair
  // select below is a fixed tap and only the shift direction depends on
  // the bit order.
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_slice;
    end else if (MSB_FIRST) begin
      r_shift <= r_shift << 2;
    end else begin
      r_shift <= r_shift >> 2;
    end
  end

  assign o_bitE = MSB_FIRST ? r_shift[RATIO-1] : r_shift[0];
  assign o_bitO = MSB_FIRST ? r_shift[RATIO-2] : r_shift[1];

endmodule

// File: rtl/hr_ser_lane_array.sv
// -----------------------------------------------------------------------------
// hr_ser_lane_array
// Purpose : Half-rate N-lane serializer. Takes one LANES*RATIO-bit word every
//           RATIO/2 cycles and emits an (even, odd) bit pair per lane per
//           cycle, with idle fill on underflow and PRBS7/clock/zero patterns.
// Ports   : clk_hr - half-rate clock, all logic on its rising edge
//           rst    - synchronous active-high reset
//           bus    - hr_ser_lane_array_if slave: din/din_valid/din_ready,
//                    mode, lane_en, clr_status, dout_e/dout_o, underflow,
//                    word_cnt
// -----------------------------------------------------------------------------
module hr_ser_lane_array
  import hr_ser_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_hr,
  input  logic                 rst,
  hr_ser_lane_array_if.slave   bus
);

  localparam int P    = RATIO / 2;
  localparam int PH_W = $clog2(P);

  logic [PH_W-1:0]        r_ph;
  ser_mode_e              r_mode;
  logic [6:0]             r_prbs;
  logic [LANES-1:0]       r_doutE;
  logic [LANES-1:0]       r_doutO;
  logic                   r_underflow;
  logic [CNT_W-1:0]       r_wordCnt;

  logic                   w_boundary;
  logic [LANES*RATIO-1:0] w_loadWord;
  logic [LANES-1:0]       w_laneE;
  logic [LANES-1:0]       w_laneO;
  logic [LANES-1:0]       w_patE;
  logic [LANES-1:0]       w_patO;
  logic [6:0]             w_prbsNext;

  assign w_boundary    = (r_ph == PH_W'(P - 1));
  assign bus.din_ready = w_boundary;

  // A missing word at a boundary is replaced by all zeros (idle fill).
  assign w_loadWord = bus.din_valid ? bus.din : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hr_ser_lane #(
      .RATIO     (RATIO),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk_hr  (clk_hr),
      .rst     (rst),
      .i_load  (w_boundary),
      .i_slice (w_loadWord[RATIO*l +: RATIO]),
      .o_bitE  (w_laneE[l]),
      .o_bitO  (w_laneO[l])
    );
  end

  // PRBS7 (x^7+x^6+1) stepped twice per cycle. Bit 6 is the older serial
  // bit and bit 5 the one after it, so the pair maps straight onto e/o.
  always_comb begin
    w_prbsNext = {r_prbs[4:0], r_prbs[6] ^ r_prbs[5], r_prbs[5] ^ r_prbs[4]};
  end

  // Output pattern selection uses the mode latched with the word now being
  // shifted, so a mode change never splits a word.
  always_comb begin
    w_patE = '0;
    w_patO = '0;
    case (r_mode)
      SER_DATA: begin
        w_patE = w_laneE;
        w_patO = w_laneO;
      end
      SER_PRBS7: begin
        w_patE = {LANES{r_prbs[6]}};
        w_patO = {LANES{r_prbs[5]}};
      end
      SER_CLK: begin
        w_patE = '1;
        w_patO = '0;
      end
      default: begin
        w_patE = '0;
        w_patO = '0;
      end
    endcase
  end

  // Phase counter and registered outputs. lane_en gates the registered pair
  // directly so disabling a lane takes effect on the very next edge.
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_ph    <= PH_W'(P - 1);
      r_doutE <= '0;
      r_doutO <= '0;
    end else begin
      r_ph    <= w_boundary ? '0 : r_ph + PH_W'(1);
      r_doutE <= w_patE & bus.lane_en;
      r_doutO <= w_patO & bus.lane_en;
    end
  end

  // Mode latch, PRBS state and word counter. The generator only runs while
  // it is feeding the outputs and restarts from the seed whenever PRBS7 is
  // newly entered, so every PRBS7 run begins with the same sequence.
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_mode    <= SER_DATA;
      r_prbs    <= PRBS_SEED;
      r_wordCnt <= '0;
    end else begin
      if (r_mode == SER_PRBS7) begin
        r_prbs <= w_prbsNext;
      end
      if (w_boundary) begin
        r_mode    <= bus.mode;
        r_wordCnt <= r_wordCnt + CNT_W'(1);
        if ((bus.mode == SER_PRBS7) && (r_mode != SER_PRBS7)) begin
          r_prbs <= PRBS_SEED;
        end
      end
    end
  end

  // Sticky underflow: a new underflow wins over a clear in the same cycle.
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (w_boundary && !bus.din_valid) begin
      r_underflow <= 1'b1;
    end else if (bus.clr_status) begin
      r_underflow <= 1'b0;
    end
  end

  assign bus.dout_e    = r_doutE;
  assign bus.dout_o    = r_doutO;
  assign bus.underflow = r_underflow;
  assign bus.word_cnt  = r_wordCnt;

endmodule

// File: tb/tb_hr_ser_lane_array.sv
// -----------------------------------------------------------------------------
// tb_hr_ser_lane_array
// Purpose : Self-checking bench for hr_ser_lane_array (LANES=4, RATIO=4).
//           A word-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_hr_ser_lane_array;
  import hr_ser_pkg::*;

  localparam int LANES     = 4;
  localparam int RATIO     = 4;
  localparam int CNT_W     = 16;
  localparam bit MSB_FIRST = 1'b0;
  localparam int P         = RATIO / 2;
  localparam int W         = LANES * RATIO;

  logic clk_hr = 1'b0;
  logic rst    = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: the word being sent, its mode, which pair goes
  // out next, a serial PRBS7 generator and the status values.
  logic [W-1:0]     mWord;
  ser_mode_e        mMode;
  int               mK;
  logic [6:0]       mLfsr;
  logic [CNT_W-1:0] mCnt;
  logic             mUf;
  int               mEdge;
  logic [LANES-1:0] expE;
  logic [LANES-1:0] expO;
  bit               prbsQ[$];

  always #5 clk_hr = ~clk_hr;

  hr_ser_lane_array_if #(.LANES(LANES), .RATIO(RATIO), .CNT_W(CNT_W)) bus ();

  hr_ser_lane_array #(
    .LANES     (LANES),
    .RATIO     (RATIO),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_hr (clk_hr),
    .rst    (rst),
    .bus    (bus)
  );

  // Serial PRBS7: emit the oldest bit, feed back x^7 xor x^6.
  function automatic logic lfsrBit(inout logic [6:0] s);
    logic b;
    b = s[6];
    s = {s[5:0], s[6] ^ s[5]};
    return b;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] d, input logic v,
                               input ser_mode_e m, input logic [LANES-1:0] en,
                               input logic c);
    bus.din        = d;
    bus.din_valid  = v;
    bus.mode       = m;
    bus.lane_en    = en;
    bus.clr_status = c;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic modelEdge();
    logic             boundary;
    logic [LANES-1:0] patE;
    logic [LANES-1:0] patO;
    logic [RATIO-1:0] slice;
    logic             b0;
    logic             b1;
    if (rst) begin
      mWord = '0;
      mMode = SER_DATA;
      mK    = 0;
      mLfsr = 7'h7F;
      mCnt  = '0;
      mUf   = 1'b0;
      mEdge = 0;
      expE  = '0;
      expO  = '0;
    end else begin
      boundary = ((mEdge % P) == 0);
      patE = '0;
      patO = '0;
      case (mMode)
        SER_DATA: begin
          for (int l = 0; l < LANES; l++) begin
            slice = mWord[RATIO*l +: RATIO];
            patE[l] = MSB_FIRST ? slice[RATIO-1-2*mK] : slice[2*mK];
            patO[l] = MSB_FIRST ? slice[RATIO-2-2*mK] : slice[2*mK+1];
          end
        end
        SER_PRBS7: begin
          b0 = lfsrBit(mLfsr);
          b1 = lfsrBit(mLfsr);
          patE = {LANES{b0}};
          patO = {LANES{b1}};
          prbsQ.push_back(bus.dout_e[0]);
          prbsQ.push_back(bus.dout_o[0]);
        end
        SER_CLK: begin
          patE = '1;
          patO = '0;
        end
        default: begin
          patE = '0;
          patO = '0;
        end
      endcase
      expE = patE & bus.lane_en;
      expO = patO & bus.lane_en;
      mK++;
      if (boundary) begin
        mCnt = mCnt + 1'b1;
        if (!bus.din_valid) mUf = 1'b1;
        else if (bus.clr_status) mUf = 1'b0;
        if (bus.mode == SER_PRBS7 && mMode != SER_PRBS7) mLfsr = 7'h7F;
        mMode = bus.mode;
        mWord = bus.din_valid ? bus.din : '0;
        mK    = 0;
      end else if (bus.clr_status) begin
        mUf = 1'b0;
      end
      mEdge++;
    end
  endtask

  task automatic checkOutput();
    checkVal("dout_e",    32'(bus.dout_e),    32'(expE));
    checkVal("dout_o",    32'(bus.dout_o),    32'(expO));
    checkVal("din_ready", 32'(bus.din_ready), 32'((mEdge % P) == 0));
    checkVal("underflow", 32'(bus.underflow), 32'(mUf));
    checkVal("word_cnt",  32'(bus.word_cnt),  32'(mCnt));
  endtask

  task automatic tick();
    @(posedge clk_hr);
    #1;
    modelEdge();
    checkOutput();
  endtask

  task automatic tickRandDin(input int n);
    for (int i = 0; i < n; i++) begin
      bus.din = W'($urandom);
      tick();
    end
  endtask

  initial begin
    int bad;

    // Reset state
    applyStimulus('0, 1'b0, SER_DATA, '1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // DATA stream starting with a known word, then random back-to-back words
    applyStimulus(16'hA5C3, 1'b1, SER_DATA, 4'hF, 1'b0);
    tick();
    for (int i = 0; i < 24; i++) begin
      if (bus.din_ready) bus.din = W'($urandom);
      tick();
    end

    // Underflow: miss exactly one boundary, then hold, then clear
    for (int i = 0; i < P && !bus.din_ready; i++) tick();
    bus.din_valid = 1'b0;
    tick();
    bus.din_valid = 1'b1;
    tickRandDin(6);
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    tickRandDin(4);

    // Switch to CLK in the middle of a word
    if (bus.din_ready) tick();
    bus.mode = SER_CLK;
    tickRandDin(8);

    // PRBS7 for more than two full periods
    prbsQ.delete();
    bus.mode = SER_PRBS7;
    tickRandDin(140);
    checkVal("prbs_len", 32'(prbsQ.size() >= 254), 32'd1);
    bad = 0;
    for (int i = 0; i + 127 < prbsQ.size(); i++) begin
      if (prbsQ[i] !== prbsQ[i+127]) bad++;
    end
    checkVal("prbs_period", 32'(bad), 32'd0);

    // DATA with lane 2 disabled
    bus.mode    = SER_DATA;
    bus.lane_en = 4'b1011;
    tickRandDin(12);
    bus.lane_en = 4'hF;
    tickRandDin(4);

    // Randomised mix of modes, gaps, lane enables and clears
    for (int i = 0; i < 300; i++) begin
      applyStimulus(W'($urandom), ($urandom_range(0, 7) != 0),
                    ser_mode_e'($urandom_range(0, 3)),
                    LANES'($urandom), ($urandom_range(0, 9) == 0));
      tick();
    end

    // Reset in the middle of a word
    applyStimulus(W'($urandom), 1'b1, SER_DATA, 4'hF, 1'b0);
    tickRandDin(5);
    if (bus.din_ready) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tickRandDin(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
